// File: rtl/round_step_display.sv
// Steps a round index through the AES-16 core on slow-clock toggles or button presses,
// and scans the selected 16-bit round state onto a 4-digit multiplexed 7-segment display.
module round_step_display #(
    parameter int unsigned NUM_ROUNDS  = 3,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        Clkin,
    input  logic        Rst,
    input  logic        Slow_clk,
    input  logic        Run,
    input  logic        Step_btn,
    input  logic        Start,
    input  logic [15:0] Round_data,
    output logic [3:0]  Round_sel,
    output logic        Done,
    output logic [6:0]  Seg,
    output logic [3:0]  An,
    output logic        Dp
);

    localparam int unsigned REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [3:0]       LAST_SEL = 4'(NUM_ROUNDS - 1);
    localparam logic [REF_W-1:0] REF_MAX  = REF_W'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHOW,
        ST_DONE
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] slow_sync;
    logic [SYNC_STAGES-1:0] step_sync;
    logic                   slow_prev;
    logic                   step_prev;
    logic                   slow_out;
    logic                   step_out;
    logic                   slow_evt;
    logic                   step_evt;
    logic                   adv;

    logic [15:0]            disp;
    logic [REF_W-1:0]       refresh_cnt;
    logic [1:0]             digit_idx;
    logic [3:0]             nibble;
    logic [6:0]             seg_next;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    // Slow_clk and Step_btn are asynchronous data: shift through the synchroniser chains
    always_ff @(posedge Clkin) begin
        if (Rst) begin
            slow_sync <= '0;
            step_sync <= '0;
            slow_prev <= 1'b0;
            step_prev <= 1'b0;
        end else begin
            slow_sync <= SYNC_STAGES'({slow_sync, Slow_clk});
            step_sync <= SYNC_STAGES'({step_sync, Step_btn});
            slow_prev <= slow_out;
            step_prev <= step_out;
        end
    end

    assign slow_out = slow_sync[SYNC_STAGES-1];
    assign step_out = step_sync[SYNC_STAGES-1];
    assign slow_evt = slow_out ^ slow_prev;
    assign step_evt = step_out & ~step_prev;
    assign adv      = Run ? slow_evt : step_evt;

    // Round stepping FSM; Start always wins over a coincident advance
    always_ff @(posedge Clkin) begin
        if (Rst) begin
            state     <= ST_IDLE;
            Round_sel <= 4'd0;
            Done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        state     <= ST_SHOW;
                        Round_sel <= 4'd0;
                    end
                end
                ST_SHOW: begin
                    if (Start) begin
                        Round_sel <= 4'd0;
                    end else if (adv) begin
                        if (Round_sel == LAST_SEL) begin
                            state <= ST_DONE;
                            Done  <= 1'b1;
                        end else begin
                            Round_sel <= Round_sel + 4'd1;
                        end
                    end
                end
                ST_DONE: begin
                    if (Start) begin
                        state     <= ST_SHOW;
                        Round_sel <= 4'd0;
                        Done      <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    Round_sel <= 4'd0;
                    Done      <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        nibble = disp[3:0];
        case (digit_idx)
            2'd0:    nibble = disp[3:0];
            2'd1:    nibble = disp[7:4];
            2'd2:    nibble = disp[11:8];
            default: nibble = disp[15:12];
        endcase
        seg_next = hex7(nibble);
    end

    // Display scan: Seg, An and Dp are loaded from the same digit index so they switch together
    always_ff @(posedge Clkin) begin
        if (Rst) begin
            disp        <= 16'h0000;
            refresh_cnt <= '0;
            digit_idx   <= 2'd0;
            An          <= 4'b1110;
            Seg         <= 7'b1000000;
            Dp          <= 1'b1;
        end else begin
            disp <= Round_data;
            if (refresh_cnt == REF_MAX) begin
                refresh_cnt <= '0;
                digit_idx   <= digit_idx + 2'd1;
            end else begin
                refresh_cnt <= refresh_cnt + REF_W'(1);
            end
            An  <= ~(4'b0001 << digit_idx);
            Seg <= seg_next;
            Dp  <= ~(Done & (digit_idx == 2'd0));
        end
    end

endmodule

// File: tb/tb_round_step_display.sv
// Self-checking bench for round_step_display: directed scenarios plus a randomized
// operation sequence checked against an abstract stage-stepping model.
module tb_round_step_display;

    localparam int unsigned NR = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        slow_clk;
    logic        run;
    logic        step_btn;
    logic        start;
    logic [15:0] round_data;
    logic [3:0]  round_sel;
    logic        done;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;

    logic [15:0] tbl [16];
    logic [6:0]  seg_tbl [16];

    int assertions = 0;
    int failures   = 0;

    // Abstract model: is a run active, which stage, finished?
    int m_active;
    int m_sel;
    int m_done;

    assign round_data = tbl[round_sel];

    round_step_display #(
        .NUM_ROUNDS (NR),
        .REFRESH_DIV(4),
        .SYNC_STAGES(2)
    ) dut (
        .Clkin     (clk),
        .Rst       (rst),
        .Slow_clk  (slow_clk),
        .Run       (run),
        .Step_btn  (step_btn),
        .Start     (start),
        .Round_data(round_data),
        .Round_sel (round_sel),
        .Done      (done),
        .Seg       (seg),
        .An        (an),
        .Dp        (dp)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_start();
        m_active = 1;
        m_sel    = 0;
        m_done   = 0;
    endtask

    task automatic model_adv();
        if (m_active == 1 && m_done == 0) begin
            if (m_sel == NR - 1) m_done = 1;
            else m_sel = m_sel + 1;
        end
    endtask

    task automatic model_rst();
        m_active = 0;
        m_sel    = 0;
        m_done   = 0;
    endtask

    function automatic logic [6:0] exp_seg(input logic [15:0] d, input int i);
        logic [15:0] sh;
        sh = d >> (4 * i);
        return seg_tbl[sh[3:0]];
    endfunction

    function automatic int an_digit(input logic [3:0] a);
        for (int i = 0; i < 4; i++)
            if (a === ~(4'b0001 << i)) return i;
        return -1;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        model_start();
    endtask

    task automatic test_reset();
        int d, prev_d, run_len, seen_change;
        rst = 1'b1;
        repeat (3) tick();
        assertions++;
        if (round_sel !== 4'd0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_fsm: sel=%0d done=%b required sel=0 done=0", round_sel, done);
        end
        assertions++;
        if (an !== 4'b1110 || seg !== 7'b1000000 || dp !== 1'b1) begin
            failures++;
            $display("FAIL reset_display: an=%b seg=%b dp=%b required 1110 1000000 1", an, seg, dp);
        end
        model_rst();
        rst = 1'b0;
        repeat (3) tick();
        prev_d = an_digit(an);
        run_len = 0;
        seen_change = 0;
        for (int k = 0; k < 32; k++) begin
            d = an_digit(an);
            assertions++;
            if (d < 0) begin
                failures++;
                $display("FAIL scan_anode: an=%b required one-hot-low", an);
            end else begin
                assertions++;
                if (seg !== exp_seg(tbl[0], d)) begin
                    failures++;
                    $display("FAIL scan_seg: digit=%0d seg=%b required %b", d, seg, exp_seg(tbl[0], d));
                end
                if (d != prev_d) begin
                    assertions++;
                    if (d != (prev_d + 1) % 4) begin
                        failures++;
                        $display("FAIL scan_order: digit %0d followed %0d", d, prev_d);
                    end
                    if (seen_change != 0) begin
                        assertions++;
                        if (run_len != 4) begin
                            failures++;
                            $display("FAIL scan_period: digit held %0d cycles required 4", run_len);
                        end
                    end
                    seen_change = 1;
                    run_len = 0;
                end
                prev_d = d;
            end
            run_len++;
            tick();
        end
        assertions++;
        if (round_sel !== 4'd0 || done !== 1'b0) begin
            failures++;
            $display("FAIL idle_hold: sel=%0d done=%b required 0 0", round_sel, done);
        end
    endtask

    task automatic test_auto_run();
        run = 1'b1;
        pulse_start();
        assertions++;
        if (round_sel !== 4'd0) begin
            failures++;
            $display("FAIL start_sel: sel=%0d required 0", round_sel);
        end
        for (int t = 0; t < 3; t++) begin
            slow_clk = ~slow_clk;
            tick();
            tick();
            assertions++;
            if (round_sel !== 4'(m_sel)) begin
                failures++;
                $display("FAIL auto_early: toggle %0d sel=%0d required %0d", t, round_sel, m_sel);
            end
            tick();
            model_adv();
            assertions++;
            if (round_sel !== 4'(m_sel) || done !== 1'(m_done)) begin
                failures++;
                $display("FAIL auto_step: toggle %0d sel=%0d done=%b required %0d %0d",
                         t, round_sel, done, m_sel, m_done);
            end
            repeat (47) tick();
        end
        for (int k = 0; k < 8; k++) begin
            assertions++;
            if (dp !== ((an === 4'b1110) ? 1'b0 : 1'b1)) begin
                failures++;
                $display("FAIL done_dp: an=%b dp=%b", an, dp);
            end
            tick();
        end
    endtask

    task automatic test_paused();
        pulse_start();
        run = 1'b0;
        slow_clk = ~slow_clk;
        repeat (10) tick();
        assertions++;
        if (round_sel !== 4'd0) begin
            failures++;
            $display("FAIL paused_toggle: sel=%0d required 0", round_sel);
        end
        step_btn = 1'b1;
        tick();
        tick();
        assertions++;
        if (round_sel !== 4'd0) begin
            failures++;
            $display("FAIL step_early: sel=%0d required 0", round_sel);
        end
        tick();
        model_adv();
        assertions++;
        if (round_sel !== 4'(m_sel)) begin
            failures++;
            $display("FAIL step_latency: sel=%0d required %0d", round_sel, m_sel);
        end
        repeat (7) tick();
        assertions++;
        if (round_sel !== 4'(m_sel)) begin
            failures++;
            $display("FAIL step_held: sel=%0d required %0d", round_sel, m_sel);
        end
        step_btn = 1'b0;
        repeat (10) tick();
        assertions++;
        if (round_sel !== 4'(m_sel)) begin
            failures++;
            $display("FAIL step_release: sel=%0d required %0d", round_sel, m_sel);
        end
    endtask

    task automatic test_start_adv_collision();
        run = 1'b1;
        repeat (3) tick();
        slow_clk = ~slow_clk;
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        model_start();
        assertions++;
        if (round_sel !== 4'd0) begin
            failures++;
            $display("FAIL start_wins: sel=%0d required 0", round_sel);
        end
        repeat (5) tick();
        assertions++;
        if (round_sel !== 4'd0) begin
            failures++;
            $display("FAIL start_wins_hold: sel=%0d required 0", round_sel);
        end
    endtask

    task automatic test_reset_midrun();
        for (int t = 0; t < 2; t++) begin
            slow_clk = ~slow_clk;
            repeat (5) tick();
            model_adv();
        end
        assertions++;
        if (round_sel !== 4'(m_sel)) begin
            failures++;
            $display("FAIL midrun_sel: sel=%0d required %0d", round_sel, m_sel);
        end
        rst = 1'b1;
        tick();
        model_rst();
        assertions++;
        if (round_sel !== 4'd0 || done !== 1'b0 || an !== 4'b1110 || seg !== 7'b1000000) begin
            failures++;
            $display("FAIL midrun_reset: sel=%0d done=%b an=%b seg=%b required 0 0 1110 1000000",
                     round_sel, done, an, seg);
        end
        rst = 1'b0;
        for (int t = 0; t < 3; t++) begin
            slow_clk = ~slow_clk;
            repeat (5) tick();
            assertions++;
            if (round_sel !== 4'd0 || done !== 1'b0) begin
                failures++;
                $display("FAIL idle_ignores: sel=%0d done=%b required 0 0", round_sel, done);
            end
        end
        pulse_start();
        slow_clk = ~slow_clk;
        repeat (5) tick();
        model_adv();
        assertions++;
        if (round_sel !== 4'(m_sel)) begin
            failures++;
            $display("FAIL restart_step: sel=%0d required %0d", round_sel, m_sel);
        end
    endtask

    task automatic test_run_ignores_step();
        step_btn = 1'b1;
        repeat (10) tick();
        step_btn = 1'b0;
        repeat (5) tick();
        assertions++;
        if (round_sel !== 4'(m_sel)) begin
            failures++;
            $display("FAIL run_step_ignored: sel=%0d required %0d", round_sel, m_sel);
        end
        for (int t = 0; t < 5; t++) begin
            slow_clk = ~slow_clk;
            repeat (5) tick();
            model_adv();
        end
        assertions++;
        if (round_sel !== 4'(NR - 1) || done !== 1'b1) begin
            failures++;
            $display("FAIL done_hold: sel=%0d done=%b required %0d 1", round_sel, done, NR - 1);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        model_start();
        assertions++;
        if (round_sel !== 4'd0 || done !== 1'b0) begin
            failures++;
            $display("FAIL done_restart: sel=%0d done=%b required 0 0", round_sel, done);
        end
    endtask

    task automatic test_random();
        int op, d, r;
        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 1));
            run = r[0];
            repeat (2) tick();
            if ($urandom_range(0, 5) == 0) pulse_start();
            op = int'($urandom_range(0, 9));
            if (op == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                model_rst();
                repeat (6) tick();
            end else if (op < 6) begin
                slow_clk = ~slow_clk;
                repeat (6) tick();
                if (r == 1) model_adv();
            end else begin
                step_btn = 1'b1;
                repeat (5) tick();
                step_btn = 1'b0;
                repeat (4) tick();
                if (r == 0) model_adv();
            end
            assertions++;
            if (round_sel !== 4'(m_sel) || done !== 1'(m_done)) begin
                failures++;
                $display("FAIL random_fsm: op %0d sel=%0d done=%b required %0d %0d",
                         n, round_sel, done, m_sel, m_done);
            end
            d = an_digit(an);
            assertions++;
            if (d < 0) begin
                failures++;
                $display("FAIL random_anode: an=%b required one-hot-low", an);
            end else if (seg !== exp_seg(tbl[m_sel], d) || dp !== ((m_done == 1 && d == 0) ? 1'b0 : 1'b1)) begin
                failures++;
                $display("FAIL random_display: digit=%0d seg=%b dp=%b required %b %b", d, seg, dp,
                         exp_seg(tbl[m_sel], d), (m_done == 1 && d == 0) ? 1'b0 : 1'b1);
            end
        end
    endtask

    initial begin
        seg_tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        tbl[0] = 16'h1234;
        for (int i = 1; i < 16; i++) tbl[i] = 16'($urandom);
        rst      = 1'b1;
        slow_clk = 1'b0;
        run      = 1'b0;
        step_btn = 1'b0;
        start    = 1'b0;
        model_rst();

        test_reset();
        test_auto_run();
        test_paused();
        test_start_adv_collision();
        test_reset_midrun();
        test_run_ignores_step();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
